timer_counter: RTL and testbench

Memory-mapped countdown timer/counter on the data-side peripheral bus, directly downstream of the CPU–peripheral bridge. Two instances are built: T1 decoded at 0x7f00–0x7f0b, T2 at 0x7f10–0x7f1b. The bridge supplies a full word address, a write enable and write data, and returns this block's read data to the CPU. Each instance raises a maskable interrupt request when its count reaches zero.

---
 rtl/timer_counter.sv | 115 +++++++++++
 tb/tb_timer_counter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// Memory-mapped countdown timer with CTRL/PRESET/COUNT registers and a maskable IRQ.
// Optional auto-reload mode is built only when TIMER_AUTORELOAD_EN is defined.
module timer_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  state_t      state;
  logic        en;
  logic        im;
  logic        irq_flag;
  logic [31:0] preset;
  logic [31:0] count;
  logic [31:0] ctrl_rd;
  logic        ctrl_wr;
  logic        preset_wr;
  logic        unused_addr_bits;

  // The bridge already range-checks, so only the word offset matters here.
  assign unused_addr_bits = ^{addr[31:4], addr[1:0]};
  assign ctrl_wr          = WE && (addr[3:2] == 2'b00);
  assign preset_wr        = WE && (addr[3:2] == 2'b01);

`ifdef TIMER_AUTORELOAD_EN
  logic [1:0] mode;
  logic       auto_reload;

  assign auto_reload = (mode == 2'b01);
  assign ctrl_rd     = {28'd0, im, mode, en};
`else
  assign ctrl_rd     = {28'd0, im, 2'b00, en};
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      en       <= 1'b0;
      im       <= 1'b0;
      irq_flag <= 1'b0;
      preset   <= 32'd0;
      count    <= 32'd0;
`ifdef TIMER_AUTORELOAD_EN
      mode     <= 2'b00;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (en) state <= LOAD;
        end
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT: begin
          // A count of 0 or 1 both finish here, so COUNT never wraps.
          if (!en) begin
            state <= IDLE;
          end else if (count > 32'd1) begin
            count <= count - 32'd1;
          end else begin
            count    <= 32'd0;
            irq_flag <= 1'b1;
            state    <= INT;
          end
        end
        INT: begin
`ifdef TIMER_AUTORELOAD_EN
          if (auto_reload) begin
            irq_flag <= 1'b0;
            state    <= LOAD;
          end else begin
            en    <= 1'b0;
            state <= IDLE;
          end
`else
          en    <= 1'b0;
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase

      // CPU writes come last so they override the FSM's own EN clear.
      if (ctrl_wr) begin
        en       <= Din[0];
        im       <= Din[3];
        irq_flag <= 1'b0;
`ifdef TIMER_AUTORELOAD_EN
        mode     <= Din[2:1];
`endif
      end
      if (preset_wr) preset <= Din;
    end
  end

  always_comb begin
    Dout = 32'd0;
    case (addr[3:2])
      2'b00:   Dout = ctrl_rd;
      2'b01:   Dout = preset;
      2'b10:   Dout = count;
      default: Dout = 32'd0;
    endcase
  end

  assign IRQ = irq_flag & im;

endmodule

// File: tb/tb_timer_counter.sv
// Randomized and directed checks of timer_counter against a closed-form timing model.
// Honors TIMER_AUTORELOAD_EN the same way the design does.
module tb_timer_counter;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  int total_checks = 0;
  int bad_checks   = 0;

  timer_counter dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .WE    (WE),
    .Din   (Din),
    .Dout  (Dout),
    .IRQ   (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_checks++;
    if (got !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic writeReg(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    Din  = d;
    WE   = 1'b1;
    @(posedge clk);
    #1;
    WE   = 1'b0;
  endtask

  task automatic readReg(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    WE   = 1'b0;
    #1;
    d = Dout;
  endtask

  task automatic doReset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  // Expected state t edges after the CTRL write that set EN, from the timing rules:
  // LOAD at t=1, COUNT=N at t=2, INT at t=N'+2 where N'=max(N,1).
  function automatic void model(input int t, input logic [31:0] n, input logic [31:0] ctrlVal,
                                input logic [31:0] c0, output logic [31:0] cnt,
                                output logic irq, output logic [31:0] ctrl);
    longint     neff;
    longint     u;
    logic       en;
    logic       flag;
    logic       ar;
    logic [1:0] modeRd;
`ifdef TIMER_AUTORELOAD_EN
    modeRd = ctrlVal[2:1];
    ar     = (ctrlVal[2:1] == 2'b01);
`else
    modeRd = 2'b00;
    ar     = 1'b0;
`endif
    neff = (n == 32'd0) ? 64'd1 : longint'({32'd0, n});
    en   = 1'b1;
    flag = 1'b0;
    cnt  = c0;
    if (t >= 2) begin
      if (!ar) begin
        u = longint'(t - 2);
        if (u < neff) begin
          cnt = n - u[31:0];
        end else begin
          cnt  = 32'd0;
          flag = 1'b1;
          en   = (longint'(t) < neff + 3);
        end
      end else begin
        u    = longint'(t - 2) % (neff + 2);
        cnt  = (u < neff) ? n - u[31:0] : 32'd0;
        flag = (u == neff);
      end
    end
    irq  = flag & ctrlVal[3];
    ctrl = {28'd0, ctrlVal[3], modeRd, en};
  endfunction

  // PRESET is assumed already equal to n; CTRL is written on the first edge.
  task automatic runScenario(input logic [31:0] n, input logic [31:0] ctrlVal, input logic [31:0] c0,
                             input int steps, input int midT, input logic [31:0] midVal);
    logic [31:0] expCnt;
    logic [31:0] expCtrl;
    logic [31:0] got;
    logic [31:0] curPreset;
    logic        expIrq;
    curPreset = n;
    writeReg(32'h7f00, ctrlVal);
    for (int t = 1; t <= steps; t++) begin
      if (t == midT) begin
        writeReg(32'h7f04, midVal);
        curPreset = midVal;
      end else begin
        tick();
      end
      model(t, n, ctrlVal, c0, expCnt, expIrq, expCtrl);
      readReg(32'h7f08, got);
      checkOutput($sformatf("count@%0d", t), got, expCnt);
      readReg(32'h7f00, got);
      checkOutput($sformatf("ctrl@%0d", t), got, expCtrl);
      readReg(32'h7f04, got);
      checkOutput($sformatf("preset@%0d", t), got, curPreset);
      checkOutput($sformatf("irq@%0d", t), {31'd0, IRQ}, {31'd0, expIrq});
    end
  endtask

  task automatic applyStimulus(input logic [31:0] n, input logic [31:0] ctrlVal, input logic [31:0] c0,
                               input int steps, input int midT, input logic [31:0] midVal);
    writeReg(32'h7f04, n);
    runScenario(n, ctrlVal, c0, steps, midT, midVal);
  endtask

  task automatic checkAllZero(input string tag);
    logic [31:0] got;
    for (int i = 0; i < 4; i++) begin
      readReg(32'h7f00 + 32'(4 * i), got);
      checkOutput($sformatf("%s_off%0d", tag, 4 * i), got, 32'd0);
    end
    checkOutput({tag, "_irq"}, {31'd0, IRQ}, 32'd0);
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] n;
    logic [1:0]  mode;
    logic        im;

    reset = 1'b0;
    addr  = 32'h7f00;
    WE    = 1'b0;
    Din   = 32'd0;
    tick();
    tick();
    checkAllZero("reset");
    reset = 1'b1;

    $display("[TB] one-shot PRESET=5");
    applyStimulus(32'd5, 32'h9, 32'd0, 10, 0, 32'd0);
    writeReg(32'h7f00, 32'h0);
    checkOutput("irq_clear", {31'd0, IRQ}, 32'd0);

    $display("[TB] auto-reload PRESET=3");
    doReset();
    applyStimulus(32'd3, 32'hB, 32'd0, 22, 0, 32'd0);

    $display("[TB] pause and write protection");
    doReset();
    applyStimulus(32'd10, 32'h1, 32'd0, 4, 0, 32'd0);
    writeReg(32'h7f00, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      readReg(32'h7f08, got);
      checkOutput("pause_count", got, 32'd7);
    end
    writeReg(32'h7f08, 32'h55);
    readReg(32'h7f08, got);
    checkOutput("count_ro", got, 32'd7);
    writeReg(32'h7f0c, 32'hffff);
    readReg(32'h7f0c, got);
    checkOutput("reserved", got, 32'd0);
    writeReg(32'h7f00, 32'hFFFFFFF0);
    readReg(32'h7f00, got);
    checkOutput("ctrl_upper", got, 32'd0);
    readReg(32'h7f04, got);
    checkOutput("preset_keep", got, 32'd10);
    readReg(32'h7f08, got);
    checkOutput("count_keep", got, 32'd7);
    applyStimulus(32'd4, 32'h1, 32'd7, 10, 0, 32'd0);

    $display("[TB] masking, preset write mid-count, simultaneous CTRL write");
    doReset();
    applyStimulus(32'd2, 32'h1, 32'd0, 8, 0, 32'd0);
    doReset();
    applyStimulus(32'd6, 32'h9, 32'd0, 12, 4, 32'd2);
    doReset();
    applyStimulus(32'd2, 32'h9, 32'd0, 4, 0, 32'd0);
    runScenario(32'd2, 32'h9, 32'd0, 8, 0, 32'd0);

    $display("[TB] boundaries");
    doReset();
    applyStimulus(32'd0, 32'h9, 32'd0, 6, 0, 32'd0);
    doReset();
    applyStimulus(32'hFFFFFFFF, 32'h9, 32'd0, 4, 0, 32'd0);
    doReset();
    applyStimulus(32'd20, 32'h9, 32'd0, 6, 0, 32'd0);
    reset = 1'b0;
    tick();
    checkAllZero("midreset");
    reset = 1'b1;
    tick();
    readReg(32'h7f08, got);
    checkOutput("postreset_count", got, 32'd0);

    $display("[TB] randomized runs");
    for (int r = 0; r < 8; r++) begin
      n    = 32'($urandom_range(0, 9));
      mode = 2'($urandom_range(0, 3));
      im   = 1'($urandom_range(0, 1));
      doReset();
      applyStimulus(n, {28'd0, im, mode, 1'b1}, 32'd0, 3 * (int'(n) + 3) + 2, 0, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
